mtm_stream_unit: RTL and testbench

//  Streaming NUM_PE x NUM_PE matrix-transpose engine with a valid/ready handshake on both sides.

---
 rtl/mtm_stream_unit.sv | 165 ++++++++++++++++
 tb/tb_mtm_stream_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : mtm_stream_unit
// Purpose  : Streaming NUM_PE x NUM_PE tile transpose with ping-pong skewed
//            banks; optional per-tile pass-through when MTM_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module mtm_stream_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_PE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0]    input_row,
`ifdef MTM_BYPASS_EN
    input  logic                                 mode_bypass,
`endif
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_PE-1:0][DATA_WIDTH-1:0]    output_row,
    output logic                                 out_last,
    output logic                                 busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [2][NUM_PE][NUM_PE];

    logic                  wr_buf_q, wr_buf_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [ADDR_WIDTH-1:0] rd_col_q, rd_col_d;
    logic [1:0]            full_q, full_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] out_row_q, out_row_d;

    logic [NUM_PE-1:0][DATA_WIDTH-1:0] wr_word;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] rd_row;
    logic                              wr_en;
    logic                              rd_load;
    logic                              rd_bypass;

`ifdef MTM_BYPASS_EN
    logic [1:0] bypass_q, bypass_d;

    // Mode is latched with the first row of a tile and follows that buffer.
    always_comb begin
        bypass_d = bypass_q;
        if (wr_en && (wr_row_q == '0)) begin
            bypass_d[wr_buf_q] = mode_bypass;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q <= '0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    assign rd_bypass = bypass_q[rd_buf_q];
`else
    assign rd_bypass = 1'b0;
`endif

    // Bank b receives lane (b - row) so that element (r,c) lands in bank (r+c)%N.
    always_comb begin
        wr_word = '0;
        for (int b = 0; b < NUM_PE; b++) begin
            wr_word[b] = input_row[ADDR_WIDTH'(b) - wr_row_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_PE; b++) begin
                mem_q[wr_buf_q][b][wr_row_q] <= wr_word[b];
            end
        end
    end

    // Transpose reads the diagonal (addr = lane); bypass reads one address row.
    always_comb begin
        rd_row = '0;
        for (int r = 0; r < NUM_PE; r++) begin
            rd_row[r] = mem_q[rd_buf_q][ADDR_WIDTH'(r) + rd_col_q]
                             [rd_bypass ? rd_col_q : ADDR_WIDTH'(r)];
        end
    end

    always_comb begin
        wr_buf_d    = wr_buf_q;
        rd_buf_d    = rd_buf_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;

        in_ready = !full_q[wr_buf_q];
        wr_en    = in_valid && in_ready;
        rd_load  = full_q[rd_buf_q] && (!out_valid_q || out_ready);

        if (wr_en) begin
            if (wr_row_q == LAST_IDX) begin
                full_d[wr_buf_q] = 1'b1;
                wr_row_d         = '0;
                wr_buf_d         = !wr_buf_q;
            end else begin
                wr_row_d = wr_row_q + ONE;
            end
        end

        // Set and clear above always hit different buffers, so both survive.
        if (rd_load) begin
            out_row_d   = rd_row;
            out_valid_d = 1'b1;
            out_last_d  = (rd_col_q == LAST_IDX);
            if (rd_col_q == LAST_IDX) begin
                full_d[rd_buf_q] = 1'b0;
                rd_col_d         = '0;
                rd_buf_d         = !rd_buf_q;
            end else begin
                rd_col_d = rd_col_q + ONE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            wr_row_q    <= '0;
            rd_col_q    <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
        end else begin
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign output_row = out_row_q;
    assign busy       = (|full_q) || (wr_row_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mtm_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtm_stream_unit
// Purpose  : Self-checking bench for mtm_stream_unit against a tile-level
//            transpose/pass-through model with a queue scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mtm_stream_unit;
    localparam int N  = 8;
    localparam int DW = 64;
    localparam int W  = N * DW;

    typedef logic [N-1:0][DW-1:0] row_t;
    typedef struct { row_t data; bit last; } exp_t;
    typedef struct { row_t data; bit mode; } src_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    row_t input_row, output_row;
`ifdef MTM_BYPASS_EN
    logic mode_bypass;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;

    exp_t exp_q[$];
    src_t src_q[$];
    row_t tile_m [N];
    int   row_m    = 0;
    bit   mode_m   = 1'b0;
    bit   acc_now  = 1'b0;
    int   acc_cnt, out_cnt, first_out, last_out, ready_low;

    mtm_stream_unit #(.DATA_WIDTH(DW), .NUM_PE(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_row  (input_row),
`ifdef MTM_BYPASS_EN
        .mode_bypass(mode_bypass),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .output_row (output_row),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < N; j++) r[j] = {$urandom(), $urandom()};
        return r;
    endfunction

    // Completed tile -> N expected output rows (transpose or pass-through).
    task automatic push_tile(input bit byp);
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.last = (k == N - 1);
            for (int j = 0; j < N; j++) e.data[j] = byp ? tile_m[k][j] : tile_m[j][k];
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        acc_cnt = 0; out_cnt = 0; first_out = -1; last_out = -1; ready_low = 0;
    endtask

    task automatic monitor();
        acc_now = 1'b0;
        if (in_valid && in_ready) begin
            acc_now = 1'b1;
            acc_cnt++;
`ifdef MTM_BYPASS_EN
            if (row_m == 0) mode_m = mode_bypass;
`else
            if (row_m == 0) mode_m = 1'b0;
`endif
            tile_m[row_m] = input_row;
            row_m++;
            if (row_m == N) begin
                push_tile(mode_m);
                row_m = 0;
            end
        end
        if (!in_ready) ready_low++;
        if (out_valid) begin
            out_cnt++;
            if (first_out < 0) first_out = cycle;
            last_out = cycle;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                exp_t e = exp_q.pop_front();
                check("out_row", output_row, e.data);
                check("out_last", out_last, e.last);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int in_pct, input int out_pct);
        in_valid  = (src_q.size() > 0) && ($urandom_range(99) < in_pct);
        input_row = in_valid ? src_q[0].data : rand_row();
`ifdef MTM_BYPASS_EN
        mode_bypass = in_valid ? src_q[0].mode : 1'($urandom_range(1));
`endif
        out_ready = ($urandom_range(99) < out_pct);
        tick();
        if (acc_now) void'(src_q.pop_front());
    endtask

    task automatic run_fixed(input int ncyc, input int in_pct, input int out_pct);
        for (int i = 0; i < ncyc; i++) drive(in_pct, out_pct);
    endtask

    task automatic run(input string tag, input int in_pct, input int out_pct, input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            drive(in_pct, out_pct);
            n++;
        end
        in_valid = 1'b0;
        check(tag, src_q.size() + exp_q.size(), 0);
    endtask

    task automatic add_tile(input bit byp, input bit pattern);
        for (int r = 0; r < N; r++) begin
            src_t s;
            s.mode = byp;
            s.data = rand_row();
            if (pattern) for (int c = 0; c < N; c++) s.data[c] = DW'(16 * r + c);
            src_q.push_back(s);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input_row = '0;
`ifdef MTM_BYPASS_EN
        mode_bypass = 1'b0;
`endif
        clear_stats();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_output_row", output_row, 0);
        @(posedge clk); #1;

        // Single patterned tile: first output row two edges after the last accept.
        add_tile(1'b0, 1'b1);
        run_fixed(N, 100, 100);
        check("t1_accepts", acc_cnt, N);
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t1_latency_valid", out_valid, 1);
        begin
            row_t r0;
            for (int j = 0; j < N; j++) r0[j] = DW'(16 * j);
            check("t1_row0_pattern", output_row, r0);
        end
        monitor();
        @(posedge clk); #1;
        run("t1_drain", 100, 100, 100);

        // Three tiles back-to-back: no input stall, contiguous output burst.
        clear_stats();
        for (int t = 0; t < 3; t++) add_tile(1'b0, 1'b0);
        run("t2_drain", 100, 100, 200);
        check("t2_ready_low", ready_low, 0);
        check("t2_out_count", out_cnt, 3 * N);
        check("t2_out_span", last_out - first_out + 1, 3 * N);

        // Stalled consumer: both buffers fill, output holds tile 0 row 0.
        clear_stats();
        for (int t = 0; t < 3; t++) add_tile(1'b0, 1'b0);
        begin
            row_t r0;
            for (int j = 0; j < N; j++) r0[j] = src_q[j].data[0];
            run_fixed(3 * N, 100, 0);
            check("t3_accepts", acc_cnt, 2 * N);
            check("t3_in_ready_low", in_ready, 0);
            check("t3_busy", busy, 1);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_row", output_row, r0);
        end
        run("t3_drain", 100, 100, 300);

        // Random handshakes over many tiles.
        for (int t = 0; t < 100; t++) add_tile(1'b0, 1'b0);
        run("t4_drain", 50, 50, 20000);

        // Reset in the middle of a tile.
        clear_stats();
        add_tile(1'b0, 1'b0);
        run_fixed(2, 100, 100);
        in_valid = 1'b0;
        check("t5_accepts", acc_cnt, 2);
        check("t5_busy_partial", busy, 1);
        rst = 1'b1;
        #3 rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        row_m = 0;
        @(negedge clk);
        check("t5_in_ready", in_ready, 1);
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        @(posedge clk); #1;
        add_tile(1'b0, 1'b0);
        run("t5_drain", 100, 100, 100);

`ifdef MTM_BYPASS_EN
        // Pass-through tile followed by a transposed tile.
        clear_stats();
        add_tile(1'b1, 1'b0);
        add_tile(1'b0, 1'b0);
        run("t6_drain", 100, 100, 200);
        check("t6_out_count", out_cnt, 2 * N);
        check("t6_out_span", last_out - first_out + 1, 2 * N);
        for (int t = 0; t < 20; t++) add_tile(1'($urandom_range(1)), 1'b0);
        run("t6_rand_drain", 50, 50, 5000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
